// File: rtl/sm_pkg.sv
// Shared types and helpers for the sign-magnitude arithmetic chain.
package sm_pkg;

  localparam int unsigned SM_WIDTH = 4;
  localparam int unsigned SM_ACC_W = 8;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } sm_state_e;

  // Sign-magnitude to two's complement; negative zero decodes to +0.
  function automatic logic [31:0] sm_to_tc(input logic        sign,
                                           input logic [31:0] mag,
                                           input int unsigned width);
    logic [31:0] m;
    m = (width >= 32) ? mag : (mag & ((32'd1 << width) - 32'd1));
    return (sign && (m != 32'd0)) ? (32'd0 - m) : m;
  endfunction

endpackage

// File: rtl/sm_accumulator_if.sv
// Sign-magnitude sample input and block-result output of the accumulator.
interface sm_accumulator_if
  import sm_pkg::*;
#(
  parameter int unsigned WIDTH = SM_WIDTH,
  parameter int unsigned ACC_W = SM_ACC_W
);

  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [WIDTH-1:0] in_mag;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [ACC_W-1:0] out_mag;
  logic             out_ovf;

  modport master (
    output in_valid, in_sign, in_mag, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_ovf
  );

  modport slave (
    input  in_valid, in_sign, in_mag, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_ovf
  );

endinterface

// File: rtl/tc_to_sm.sv
// Two's complement to sign-magnitude; zero is always reported as +0.
module tc_to_sm #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_tc,
  output logic         o_sign_c,
  output logic [W-1:0] o_mag_c
);

  logic [W-1:0] w_mag;

  // The most negative value maps to 2^(W-1), which still fits in W bits.
  assign w_mag    = i_tc[W-1] ? W'(~i_tc + W'(1)) : i_tc;
  assign o_mag_c  = w_mag;
  assign o_sign_c = i_tc[W-1] & (w_mag != '0);

endmodule

// File: rtl/sm_accumulator.sv
// Accumulates COUNT sign-magnitude samples and emits the block total as sign-magnitude.
// Build option: define SM_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module sm_accumulator
  import sm_pkg::*;
#(
  parameter int unsigned WIDTH = SM_WIDTH,
  parameter int unsigned ACC_W = SM_ACC_W,
  parameter int unsigned COUNT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  sm_accumulator_if.slave bus
);

  localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [1:0] S_ACCUM   = ACCUM;
  localparam logic [1:0] S_CONVERT = CONVERT;
  localparam logic [1:0] S_HOLD    = HOLD;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam logic [ACC_W-1:0] SAT_POS  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_NEG  = ACC_W'(~SAT_POS + ACC_W'(1));

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_out_sign;
  logic [ACC_W-1:0] r_out_mag;
  logic             r_out_ovf;

  logic [1:0]       w_state_nxt;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic             w_out_sign_nxt;
  logic [ACC_W-1:0] w_out_mag_nxt;
  logic             w_out_ovf_nxt;

  logic             w_in_xfer;
  logic [SUM_W-1:0] w_term;
  logic [SUM_W-1:0] w_sum;
  logic             w_sum_ovf;
  logic [ACC_W-1:0] w_acc_step;
  logic             w_cv_sign;
  logic [ACC_W-1:0] w_cv_mag;

  assign w_in_xfer = bus.in_valid & r_in_ready;
  assign w_term    = SUM_W'(sm_to_tc(bus.in_sign, 32'(bus.in_mag), WIDTH));
  assign w_sum     = {r_acc[ACC_W-1], r_acc} + w_term;
  // Out of range exactly when the extra sign bit disagrees with the ACC_W sign bit.
  assign w_sum_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

`ifdef SM_ACC_SATURATE_EN
  assign w_acc_step = !w_sum_ovf    ? w_sum[ACC_W-1:0] :
                      w_sum[ACC_W]  ? SAT_NEG : SAT_POS;
`else
  assign w_acc_step = w_sum[ACC_W-1:0];
`endif

  tc_to_sm #(.W(ACC_W)) u_tc_to_sm (
    .i_tc     (r_acc),
    .o_sign_c (w_cv_sign),
    .o_mag_c  (w_cv_mag)
  );

  // Next-state and registered-output logic; clear overrides every handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;
    w_out_sign_nxt  = r_out_sign;
    w_out_mag_nxt   = r_out_mag;
    w_out_ovf_nxt   = r_out_ovf;

    case (r_state)
      S_ACCUM: begin
        if (w_in_xfer) begin
          w_acc_nxt = w_acc_step;
          w_ovf_nxt = r_ovf | w_sum_ovf;
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_CONVERT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_CONVERT: begin
        w_out_sign_nxt  = w_cv_sign;
        w_out_mag_nxt   = w_cv_mag;
        w_out_ovf_nxt   = r_ovf;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_HOLD;
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          w_acc_nxt       = '0;
          w_cnt_nxt       = '0;
          w_ovf_nxt       = 1'b0;
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_ACCUM;
        end
      end
      default: begin
        w_acc_nxt       = '0;
        w_cnt_nxt       = '0;
        w_ovf_nxt       = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_ACCUM;
      end
    endcase

    if (clear) begin
      w_acc_nxt       = '0;
      w_cnt_nxt       = '0;
      w_ovf_nxt       = 1'b0;
      w_out_valid_nxt = 1'b0;
      w_state_nxt     = S_ACCUM;
    end
  end

  assign w_in_ready_nxt = (w_state_nxt == S_ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_mag   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_sign  <= w_out_sign_nxt;
      r_out_mag   <= w_out_mag_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sign  = r_out_sign;
  assign bus.out_mag   = r_out_mag;
  assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sm_accumulator.sv
// Scoreboard bench for sm_accumulator: a COUNT=4 instance and a COUNT=16 instance.
module tb_sm_accumulator;
  import sm_pkg::*;

  localparam int ACC_MAX = 127;
  localparam int ACC_MIN = -128;

  typedef struct {
    logic        sign;
    logic [31:0] mag;
    logic        ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int m_acc[2];
  bit m_ovf[2];
  int m_cnt[2];
  int m_count[2];

  sm_accumulator_if #(.WIDTH(4), .ACC_W(8)) bus_a ();
  sm_accumulator_if #(.WIDTH(4), .ACC_W(8)) bus_b ();

  sm_accumulator #(.WIDTH(4), .ACC_W(8), .COUNT(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_a.slave));

  sm_accumulator #(.WIDTH(4), .ACC_W(8), .COUNT(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_b.slave));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int acc_step(input int acc, input int term, output bit hit);
    int s;
    s   = acc + term;
    hit = (s > ACC_MAX) || (s < ACC_MIN);
    if (hit) begin
`ifdef SM_ACC_SATURATE_EN
      s = (s > 0) ? ACC_MAX : -ACC_MAX;
`else
      s = (s > ACC_MAX) ? s - 256 : s + 256;
`endif
    end
    return s;
  endfunction

  task automatic model_reset(input int sel);
    m_acc[sel] = 0;
    m_ovf[sel] = 1'b0;
    m_cnt[sel] = 0;
  endtask

  // Drive one sample, wait (bounded) for acceptance, then update the model.
  task automatic send(input int sel, input logic s, input logic [3:0] m);
    int  t;
    bit  hit;
    int  term;
    exp_t e;
    logic rdy;
    t = 0;
    if (sel == 0) begin bus_a.in_valid = 1'b1; bus_a.in_sign = s; bus_a.in_mag = m; end
    else          begin bus_b.in_valid = 1'b1; bus_b.in_sign = s; bus_b.in_mag = m; end
    rdy = (sel == 0) ? bus_a.in_ready : bus_b.in_ready;
    while (!rdy && t < 50) begin
      @(posedge clk); #1;
      t++;
      rdy = (sel == 0) ? bus_a.in_ready : bus_b.in_ready;
    end
    if (!rdy) begin
      check_eq("send_in_ready_timeout", 32'(rdy), 1);
    end else begin
      @(posedge clk); #1;
      term       = (s && m != 4'd0) ? -int'(m) : int'(m);
      m_acc[sel] = acc_step(m_acc[sel], term, hit);
      m_ovf[sel] = m_ovf[sel] | hit;
      m_cnt[sel]++;
      if (m_cnt[sel] == m_count[sel]) begin
        e.sign = (m_acc[sel] < 0);
        e.mag  = 32'((m_acc[sel] < 0) ? -m_acc[sel] : m_acc[sel]);
        e.ovf  = m_ovf[sel];
        if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
        model_reset(sel);
      end
    end
    if (sel == 0) bus_a.in_valid = 1'b0; else bus_b.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int sel);
    int t;
    t = 0;
    while (((sel == 0) ? q_a.size() : q_b.size()) != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("drain", 32'((sel == 0) ? q_a.size() : q_b.size()), 0);
  endtask

  task automatic wait_valid_a();
    int t;
    t = 0;
    while (!bus_a.out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("out_valid_timeout", 32'(bus_a.out_valid), 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
      check_eq("a_out_expected", 32'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        e_a = q_a.pop_front();
        check_eq("a_out_sign", 32'(bus_a.out_sign), 32'(e_a.sign));
        check_eq("a_out_mag", 32'(bus_a.out_mag), e_a.mag);
        check_eq("a_out_ovf", 32'(bus_a.out_ovf), 32'(e_a.ovf));
      end
    end
    if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
      check_eq("b_out_expected", 32'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        e_b = q_b.pop_front();
        check_eq("b_out_sign", 32'(bus_b.out_sign), 32'(e_b.sign));
        check_eq("b_out_mag", 32'(bus_b.out_mag), e_b.mag);
        check_eq("b_out_ovf", 32'(bus_b.out_ovf), 32'(e_b.ovf));
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_out_valid"}, 32'(bus_a.out_valid), 0);
    check_eq({tag, "_out_sign"}, 32'(bus_a.out_sign), 0);
    check_eq({tag, "_out_mag"}, 32'(bus_a.out_mag), 0);
    check_eq({tag, "_out_ovf"}, 32'(bus_a.out_ovf), 0);
    check_eq({tag, "_in_ready"}, 32'(bus_a.in_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_count[0] = 4;
    m_count[1] = 16;
    model_reset(0);
    model_reset(1);
    bus_a.in_valid = 1'b0; bus_a.in_sign = 1'b0; bus_a.in_mag = 4'd0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_sign = 1'b0; bus_b.in_mag = 4'd0; bus_b.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_release_in_ready", 32'(bus_a.in_ready), 1);

    // +3 -5 +7 -1 = +4; CONVERT then one HOLD cycle with out_ready high
    send(0, 1'b0, 4'd3); send(0, 1'b1, 4'd5); send(0, 1'b0, 4'd7); send(0, 1'b1, 4'd1);
    check_eq("t1_convert_in_ready", 32'(bus_a.in_ready), 0);
    check_eq("t1_convert_out_valid", 32'(bus_a.out_valid), 0);
    @(posedge clk); #1;
    check_eq("t1_hold_out_valid", 32'(bus_a.out_valid), 1);
    check_eq("t1_hold_in_ready", 32'(bus_a.in_ready), 0);
    @(posedge clk); #1;
    check_eq("t1_back_in_ready", 32'(bus_a.in_ready), 1);
    check_eq("t1_back_out_valid", 32'(bus_a.out_valid), 0);
    wait_drain(0);

    // -43 and a block of negative zeros
    for (int i = 0; i < 3; i++) send(0, 1'b1, 4'd15);
    send(0, 1'b0, 4'd2);
    for (int i = 0; i < 4; i++) send(0, 1'b1, 4'd0);
    wait_drain(0);

    // COUNT=16 overflow in both directions
    for (int i = 0; i < 16; i++) send(1, 1'b0, 4'd15);
    for (int i = 0; i < 16; i++) send(1, 1'b1, 4'd15);
    wait_drain(1);

    // Backpressure: result held, in_valid pulses ignored
    bus_a.out_ready = 1'b0;
    send(0, 1'b0, 4'd1); send(0, 1'b0, 4'd2); send(0, 1'b0, 4'd3); send(0, 1'b0, 4'd4);
    wait_valid_a();
    for (int i = 0; i < 5; i++) begin
      bus_a.in_valid = i[0]; bus_a.in_sign = 1'b0; bus_a.in_mag = 4'd7;
      @(posedge clk); #1;
      check_eq("bp_out_valid", 32'(bus_a.out_valid), 1);
      check_eq("bp_out_sign", 32'(bus_a.out_sign), 0);
      check_eq("bp_out_mag", 32'(bus_a.out_mag), 10);
      check_eq("bp_out_ovf", 32'(bus_a.out_ovf), 0);
      check_eq("bp_in_ready", 32'(bus_a.in_ready), 0);
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    wait_drain(0);
    for (int i = 0; i < 4; i++) send(0, 1'b0, 4'd1);
    wait_drain(0);

    // clear after two samples; the sample beside clear is dropped
    send(0, 1'b0, 4'd9); send(0, 1'b0, 4'd9);
    bus_a.in_valid = 1'b1; bus_a.in_sign = 1'b0; bus_a.in_mag = 4'd5; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; bus_a.in_valid = 1'b0;
    model_reset(0);
    check_eq("clr_in_ready", 32'(bus_a.in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("clr_no_out_valid", 32'(bus_a.out_valid), 0);
    end
    for (int i = 0; i < 4; i++) send(0, 1'b0, 4'd1);
    wait_drain(0);

    // clear during HOLD
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 1'b0, 4'd2);
    wait_valid_a();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_eq("clr_hold_out_valid", 32'(bus_a.out_valid), 0);
    check_eq("clr_hold_in_ready", 32'(bus_a.in_ready), 1);
    if (q_a.size() > 0) void'(q_a.pop_front());
    bus_a.out_ready = 1'b1;

    // asynchronous reset mid-ACCUM
    send(0, 1'b0, 4'd5); send(0, 1'b0, 4'd5);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("arst_accum");
    model_reset(0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("arst_accum_in_ready", 32'(bus_a.in_ready), 1);

    // asynchronous reset mid-HOLD
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 1'b0, 4'd7);
    wait_valid_a();
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("arst_hold");
    if (q_a.size() > 0) void'(q_a.pop_front());
    #3 rst_n = 1'b1;
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("arst_hold_in_ready", 32'(bus_a.in_ready), 1);

    // clean block after reset: +7 -2 -0 +1 = +6
    send(0, 1'b0, 4'd7); send(0, 1'b1, 4'd2); send(0, 1'b1, 4'd0); send(0, 1'b0, 4'd1);
    wait_drain(0);
    wait_drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
